writeback_arbiter: RTL

//   Writeback stage directly upstream of the register file write port (addr_w/data_w/write_en).

---
 rtl/cpu_wb_pkg.sv | 35 +++
 rtl/wb_starve_ctr.sv | 32 +++
 rtl/writeback_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_wb_pkg.sv
// Shared types for the writeback arbiter: priority states, grant source encoding
// and the hard-wired zero register index.
package cpu_wb_pkg;

    typedef enum logic {
        PRI_LSU = 1'b0,
        PRI_ALU = 1'b1
    } wb_pri_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2
    } wb_src_e;

    localparam int unsigned REG_ZERO = 0;

    // Two-way priority pick: the first source wins when valid, else the second.
    function automatic wb_src_e wb_pick(
        input logic    first_valid,
        input wb_src_e first_src,
        input logic    second_valid,
        input wb_src_e second_src
    );
        wb_src_e pick;
        pick = SRC_NONE;
        if (first_valid) begin
            pick = first_src;
        end else if (second_valid) begin
            pick = second_src;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive stalled ALU cycles; starve_hit flags the stall
// that brings the count to LIMIT so the arbiter can hand the ALU the next cycle.
module wb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic ready,
    output logic starve_hit
);

    localparam int unsigned CTR_W = $clog2(LIMIT + 1);

    logic [CTR_W-1:0] cnt;
    logic             stall;

    assign stall      = valid && !ready;
    assign starve_hit = stall && (cnt == CTR_W'(LIMIT - 1));

    // Clears on idle or transfer, and when the hit hands priority over.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!stall || starve_hit) begin
            cnt <= '0;
        end else if (cnt != CTR_W'(LIMIT)) begin
            cnt <= cnt + CTR_W'(1);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the register file write port.
// Define WB_STARVE_GUARD_EN to give a starved ALU one cycle of priority.
module writeback_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
`ifdef WB_STARVE_GUARD_EN
    parameter int unsigned STARVE_LIMIT = 4,
`endif
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic [ADDR_W-1:0] addr_w,
    output logic [DATA_W-1:0] data_w,
    output logic              write_en,
    output logic [CNT_W-1:0]  wb_count
);

    wb_src_e           grant;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              sel_commit;

`ifdef WB_STARVE_GUARD_EN
    wb_pri_e pri;
    logic    starve_hit;

    wb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .valid      (alu_valid),
        .ready      (alu_ready),
        .starve_hit (starve_hit)
    );

    // Priority FSM: one ALU-first cycle after a starvation hit, then back to LSU-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri <= PRI_LSU;
        end else begin
            case (pri)
                PRI_LSU: if (starve_hit) pri <= PRI_ALU;
                PRI_ALU: pri <= PRI_LSU;
                default: pri <= PRI_LSU;
            endcase
        end
    end
`endif

    // Grant selection; nothing is accepted while in reset.
    always_comb begin
        grant = SRC_NONE;
        if (!rst) begin
`ifdef WB_STARVE_GUARD_EN
            if (pri == PRI_ALU) begin
                grant = wb_pick(alu_valid, SRC_ALU, lsu_valid, SRC_LSU);
            end else begin
                grant = wb_pick(lsu_valid, SRC_LSU, alu_valid, SRC_ALU);
            end
`else
            grant = wb_pick(lsu_valid, SRC_LSU, alu_valid, SRC_ALU);
`endif
        end
    end

    assign alu_ready = (grant == SRC_ALU);
    assign lsu_ready = (grant == SRC_LSU);

    always_comb begin
        sel_rd   = lsu_rd;
        sel_data = lsu_data;
        if (grant == SRC_ALU) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    assign sel_commit = (grant != SRC_NONE) && (sel_rd != ADDR_W'(REG_ZERO));

    // Write port registers; an R0 beat is consumed but never strobes or counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_w   <= '0;
            data_w   <= '0;
            write_en <= 1'b0;
            wb_count <= '0;
        end else begin
            write_en <= sel_commit;
            if (grant != SRC_NONE) begin
                addr_w <= sel_rd;
                data_w <= sel_data;
            end
            if (sel_commit) begin
                wb_count <= wb_count + CNT_W'(1);
            end
        end
    end

endmodule
